axil_write_master: RTL and testbench

Synthesizable AXI4-Lite write-only master that sits directly upstream of the myLED AXI slave and replaces the bench-only write task with hardware. It accepts single-beat write commands on a valid/ready port and drives the AW, W and B channels. AW and W handshakes complete independently and in either order. It reports the slave's response, or a local timeout, on a one-cycle completion pulse.

---
 rtl/axil_write_master_if.sv | 40 ++++
 rtl/axil_write_master.sv | 175 +++++++++++++++++
 tb/tb_axil_write_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_write_master_if.sv
// axil_write_master_if
// AXI4-Lite write-channel bundle (AW, W, B) between a write master and a slave.
// Signal names match the AXI master port names so the bundle drops in where
// the discrete ports used to be.
//   master modport: drives AWADDR/AWPROT/AWVALID, WDATA/WSTRB/WVALID, BREADY
//   slave  modport: drives AWREADY, WREADY, BRESP/BVALID
interface axil_write_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/axil_write_master.sv
// axil_write_master
// Single-beat AXI4-Lite write master. Accepts one command at a time on a
// valid/ready port, drives AW and W (handshaking independently, either order),
// waits for B with a bounded timeout, and reports the outcome on a one-cycle
// done pulse.
//   M_AXI_ACLK / M_AXI_ARESETN : clock, synchronous active-low reset
//   cmd_valid/cmd_ready, cmd_addr/cmd_data/cmd_strb : write command
//   busy                        : a transaction is in progress
//   done_valid/done_resp/done_timeout : completion report (held between pulses)
//   m_axi                       : AW/W/B channels (master modport)
module axil_write_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT          = 255
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_strb,
    output logic                            busy,
    output logic                            done_valid,
    output logic [1:0]                      done_resp,
    output logic                            done_timeout,
    axil_write_master_if.master             m_axi
);
    localparam int STRB_WIDTH = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP, DONE} state_e;

    state_e                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]           wstrb_q, wstrb_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            bready_q, bready_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic [7:0]                      cnt_q, cnt_d;
    logic                            cmd_ready_q, cmd_ready_d;
    logic                            busy_q, busy_d;
    logic                            done_valid_q, done_valid_d;
    logic [1:0]                      done_resp_q, done_resp_d;
    logic                            done_timeout_q, done_timeout_d;
    logic                            aw_hs, w_hs;

    always_comb begin
        state_d        = state_q;
        awaddr_d       = awaddr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        bready_d       = bready_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        cnt_d          = cnt_q;
        done_resp_d    = done_resp_q;
        done_timeout_d = done_timeout_q;
        aw_hs          = awvalid_q && m_axi.M_AXI_AWREADY;
        w_hs           = wvalid_q && m_axi.M_AXI_WREADY;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    awaddr_d  = cmd_addr;
                    wdata_d   = cmd_data;
                    wstrb_d   = cmd_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ADDR_DATA;
                end
            end
            ADDR_DATA: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Include this edge's handshakes so a simultaneous AW+W
                // completion moves on without an extra cycle.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                // A response on the final counted edge still wins over timeout.
                if (m_axi.M_AXI_BVALID && bready_q) begin
                    done_resp_d    = m_axi.M_AXI_BRESP;
                    done_timeout_d = 1'b0;
                    bready_d       = 1'b0;
                    state_d        = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(C_TIMEOUT)) begin
                        done_resp_d    = 2'b10;
                        done_timeout_d = 1'b1;
                        bready_d       = 1'b0;
                        state_d        = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        cmd_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        done_valid_d = (state_d == DONE);
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q        <= IDLE;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            bready_q       <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            cnt_q          <= '0;
            cmd_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_valid_q   <= 1'b0;
            done_resp_q    <= 2'b00;
            done_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            awaddr_q       <= awaddr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            bready_q       <= bready_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            cnt_q          <= cnt_d;
            cmd_ready_q    <= cmd_ready_d;
            busy_q         <= busy_d;
            done_valid_q   <= done_valid_d;
            done_resp_q    <= done_resp_d;
            done_timeout_q <= done_timeout_d;
        end
    end

    assign cmd_ready           = cmd_ready_q;
    assign busy                = busy_q;
    assign done_valid          = done_valid_q;
    assign done_resp           = done_resp_q;
    assign done_timeout        = done_timeout_q;
    assign m_axi.M_AXI_AWADDR  = awaddr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
endmodule

// File: tb/tb_axil_write_master.sv
// Testbench for axil_write_master with a small register-file slave whose
// first register's low nibble stands in for the LED outputs.
module tb_axil_write_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [SW-1:0] cmd_strb;
    logic          busy;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic          done_timeout;

    always #5 clk = ~clk;

    axil_write_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axil_write_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_TIMEOUT(TO)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESETN(rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .cmd_strb(cmd_strb),
        .busy(busy),
        .done_valid(done_valid),
        .done_resp(done_resp),
        .done_timeout(done_timeout),
        .m_axi(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave behaviour knobs, set per transaction by the main sequence.
    int            s_aw_dly = 0, s_w_dly = 0, s_b_dly = 0;
    bit            s_b_never = 1'b0;
    logic [1:0]    s_b_resp = 2'b00;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_data = '0;
    logic [SW-1:0] cur_strb = '0;
    int            aw_hi = 0, w_hi = 0;
    logic [DW-1:0] smem [4];
    logic [3:0]    led;
    logic [DW-1:0] exp_mem [4];

    // Slave: counts valid cycles, raises READY after the configured delay,
    // answers B after its delay unless told to stay silent.
    initial begin : slave
        int ac, wc, bc;
        logic [AW-1:0] got_addr;
        logic [DW-1:0] got_data;
        logic [SW-1:0] got_strb;
        ac = 0; wc = 0; bc = 0;
        got_addr = '0; got_data = '0; got_strb = '0;
        for (int i = 0; i < 4; i++) smem[i] = '0;
        led = 4'h0;
        bus.M_AXI_AWREADY = 1'b0;
        bus.M_AXI_WREADY  = 1'b0;
        bus.M_AXI_BVALID  = 1'b0;
        bus.M_AXI_BRESP   = 2'b00;
        forever begin
            @(negedge clk);
            if (bus.M_AXI_AWVALID === 1'b1) begin
                aw_hi++;
                check("awaddr_stable", bus.M_AXI_AWADDR, cur_addr);
                check("awprot", bus.M_AXI_AWPROT, 0);
                bus.M_AXI_AWREADY = (ac == s_aw_dly);
                if (ac == s_aw_dly) got_addr = bus.M_AXI_AWADDR;
                ac++;
            end else begin
                bus.M_AXI_AWREADY = 1'b0;
                ac = 0;
            end
            if (bus.M_AXI_WVALID === 1'b1) begin
                w_hi++;
                check("wdata_stable", bus.M_AXI_WDATA, cur_data);
                check("wstrb_stable", bus.M_AXI_WSTRB, cur_strb);
                bus.M_AXI_WREADY = (wc == s_w_dly);
                if (wc == s_w_dly) begin
                    got_data = bus.M_AXI_WDATA;
                    got_strb = bus.M_AXI_WSTRB;
                end
                wc++;
            end else begin
                bus.M_AXI_WREADY = 1'b0;
                wc = 0;
            end
            if (bus.M_AXI_BREADY === 1'b1) begin
                bus.M_AXI_BVALID = !s_b_never && (bc == s_b_dly);
                bus.M_AXI_BRESP  = s_b_resp;
                if (bus.M_AXI_BVALID) begin
                    for (int b = 0; b < SW; b++)
                        if (got_strb[b]) smem[got_addr[3:2]][8*b +: 8] = got_data[8*b +: 8];
                    led = smem[0][3:0];
                end
                bc++;
            end else begin
                bus.M_AXI_BVALID = 1'b0;
                bc = 0;
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int awd, input int wd, input int bd, input bit never,
                            input logic [1:0] rsp);
        int n, lat, exp_lat, m;
        bit timed_out;
        s_aw_dly = awd; s_w_dly = wd; s_b_dly = bd; s_b_never = never; s_b_resp = rsp;
        cur_addr = a; cur_data = d; cur_strb = s;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("cmd_ready_wait", cmd_ready, 1);
        aw_hi = 0; w_hi = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_strb = s;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (done_valid !== 1'b1 && lat < 400) begin
            check("busy_during", busy, 1);
            check("cmd_ready_during", cmd_ready, 0);
            @(negedge clk);
            lat++;
        end
        timed_out = never || (bd >= TO);
        m = (awd > wd) ? awd : wd;
        exp_lat = timed_out ? (2 + m + TO) : (3 + m + bd);
        check("done_valid", done_valid, 1);
        check("latency", lat, exp_lat);
        check("done_resp", done_resp, timed_out ? 2'b10 : rsp);
        check("done_timeout", done_timeout, timed_out);
        check("busy_done", busy, 1);
        check("aw_valid_cycles", aw_hi, awd + 1);
        check("w_valid_cycles", w_hi, wd + 1);
        if (!timed_out)
            for (int b = 0; b < SW; b++)
                if (s[b]) exp_mem[a[3:2]][8*b +: 8] = d[8*b +: 8];
        @(negedge clk);
        check("done_single", done_valid, 0);
        check("done_resp_hold", done_resp, timed_out ? 2'b10 : rsp);
        check("done_timeout_hold", done_timeout, timed_out);
        check("bready_low", bus.M_AXI_BREADY, 0);
        check("busy_after", busy, 0);
        check("cmd_ready_after", cmd_ready, 1);
        check("led", led, exp_mem[0][3:0]);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc, ndone, last, sent;
        for (int i = 0; i < 4; i++) exp_mem[i] = '0;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
        repeat (3) @(negedge clk);
        check("rst_awvalid", bus.M_AXI_AWVALID, 0);
        check("rst_wvalid", bus.M_AXI_WVALID, 0);
        check("rst_bready", bus.M_AXI_BREADY, 0);
        check("rst_awaddr", bus.M_AXI_AWADDR, 0);
        check("rst_wdata", bus.M_AXI_WDATA, 0);
        check("rst_wstrb", bus.M_AXI_WSTRB, 0);
        check("rst_awprot", bus.M_AXI_AWPROT, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_resp", done_resp, 0);
        check("rst_done_timeout", done_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_release", cmd_ready, 1);

        // Directed cases
        do_write(32'h0, 32'h5, 4'hF, 0, 0, 0, 1'b0, 2'b00);
        check("led_5", led, 4'b0101);
        do_write(32'h0, 32'h6, 4'hF, 3, 0, 0, 1'b0, 2'b00);
        do_write(32'h4, 32'hDEADBEEF, 4'hA, 0, 3, 0, 1'b0, 2'b00);
        do_write(32'h8, 32'h1234, 4'hF, 0, 0, 0, 1'b1, 2'b00);
        do_write(32'h0, 32'h9, 4'hF, 1, 2, TO - 1, 1'b0, 2'b01);
        do_write(32'h0, 32'h3, 4'hF, 0, 0, TO, 1'b0, 2'b00);
        do_write(32'hC, 32'h77, 4'h1, 2, 2, 1, 1'b0, 2'b11);

        // Reset in the middle of a transaction
        s_aw_dly = 20; s_w_dly = 20; s_b_never = 1'b0; s_b_dly = 0;
        cur_addr = 32'h0; cur_data = 32'hF; cur_strb = 4'hF;
        cmd_valid = 1'b1; cmd_addr = 32'h0; cmd_data = 32'hF; cmd_strb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_awvalid_before", bus.M_AXI_AWVALID, 1);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_awvalid", bus.M_AXI_AWVALID, 0);
        check("mid_wvalid", bus.M_AXI_WVALID, 0);
        check("mid_bready", bus.M_AXI_BREADY, 0);
        check("mid_done_valid", done_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("mid_cmd_ready_release", cmd_ready, 1);
        check("mid_no_done", done_valid, 0);
        do_write(32'h0, 32'hA, 4'hF, 0, 0, 0, 1'b0, 2'b00);
        check("led_A", led, 4'b1010);

        // Randomized writes
        for (int i = 0; i < 24; i++) begin
            logic [AW-1:0] a;
            a = {28'h0, 2'($urandom_range(0, 3)), 2'b00};
            do_write(a, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5),
                     ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
        end

        // Back-to-back sweep with cmd_valid kept asserted
        s_aw_dly = 0; s_w_dly = 0; s_b_dly = 0; s_b_never = 1'b0; s_b_resp = 2'b00;
        cmd_addr = 32'h0; cmd_strb = 4'hF; cur_addr = 32'h0; cur_strb = 4'hF;
        cyc = 0; ndone = 0; last = 0; sent = 0;
        while (ndone < 16 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (done_valid === 1'b1) begin
                exp_mem[0] = 32'(ndone);
                check("sweep_resp", done_resp, 2'b00);
                check("sweep_timeout", done_timeout, 0);
                check("sweep_led", led, exp_mem[0][3:0]);
                if (ndone > 0) check("sweep_spacing", cyc - last, 4);
                last = cyc;
                ndone++;
            end
            if (cmd_ready === 1'b1) begin
                if (sent < 16) begin
                    cmd_data = 32'(sent); cur_data = 32'(sent);
                    cmd_valid = 1'b1;
                    sent++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        check("sweep_count", ndone, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
